// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: per-requester request
// fields packed side by side, plus the shared registered response.
interface dmem_port_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned AW    = 8
) ();
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_we;
  logic [NREQ*AW-1:0]       req_addr;
  logic [NREQ*32*LANES-1:0] req_wdata;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          rsp_valid;
  logic                     rsp_we;
  logic [32*LANES-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported vector data memory among NREQ
// requesters; one grant per cycle, one-cycle registered response.
module dmem_port_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned SW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  req_bus,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [32*LANES-1:0] mem_wdata,
  input  logic [32*LANES-1:0] mem_rdata,
  output logic [SW-1:0]       stall_cnt
);
  localparam int unsigned DW = 32*LANES;
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] rsp_valid_q;
  logic            rsp_we_q;

  // Search starts at ptr and wraps; the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!found && req_bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (reset) found = 1'b0;
    grant = '0;
    if (found) grant[win] = 1'b1;
    ptr_nxt = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
  end

  // One-hot AND-OR mux; an empty grant vector leaves the port at zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        mem_we    = req_bus.req_we[k];
        mem_addr  = req_bus.req_addr[k*AW +: AW];
        mem_wdata = req_bus.req_wdata[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      rsp_valid_q <= '0;
      rsp_we_q    <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      rsp_valid_q <= grant;
      rsp_we_q    <= mem_we;
      if (found) ptr <= ptr_nxt;
      if (|(req_bus.req_valid & ~grant) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign req_bus.req_ready = grant;
  assign req_bus.rsp_valid = rsp_valid_q;
  assign req_bus.rsp_we    = rsp_we_q;
  assign req_bus.rsp_rdata = (|rsp_valid_q && !rsp_we_q && !reset) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a reference arbiter/memory model
// predicts grants and queues responses, which are popped one cycle later.
module tb_dmem_port_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned LANES = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned SW    = 16;
  localparam int unsigned W     = 32*LANES;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic            we;
    logic [W-1:0]    data;
  } rsp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.NREQ(NREQ), .LANES(LANES), .AW(AW)) bus ();
  dmem_port_arbiter_if #(.NREQ(NREQ), .LANES(LANES), .AW(AW)) sat_bus ();

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;
  logic [SW-1:0] stall_cnt;

  logic          sat_mem_we;
  logic [AW-1:0] sat_mem_addr;
  logic [W-1:0]  sat_mem_wdata;
  logic [W-1:0]  sat_mem_rdata;
  logic [3:0]    sat_stall_cnt;

  dmem_port_arbiter #(.NREQ(NREQ), .LANES(LANES), .AW(AW), .SW(SW)) dut (
    .clk(clk), .reset(reset), .req_bus(bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  dmem_port_arbiter #(.NREQ(NREQ), .LANES(LANES), .AW(AW), .SW(4)) sat_dut (
    .clk(clk), .reset(reset), .req_bus(sat_bus),
    .mem_we(sat_mem_we), .mem_addr(sat_mem_addr), .mem_wdata(sat_mem_wdata),
    .mem_rdata(sat_mem_rdata), .stall_cnt(sat_stall_cnt)
  );

  // Environment memory with a registered read port; ref_mem is the model copy.
  logic [W-1:0] mem     [2**AW];
  logic [W-1:0] ref_mem [2**AW];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q[$];
  op_t  opq[NREQ][$];
  int   glog[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] init_word(input int a);
    logic [W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*32 +: 32] = 32'(a * 16 + l) ^ 32'h5a00_0000;
    return v;
  endfunction

  // Reference model: predicts ready and memory port, queues the response.
  initial begin : monitor
    int              mptr;
    logic [SW-1:0]   mstall;
    rsp_t            e;
    logic [NREQ-1:0] xr;
    int              w;
    logic            found;
    logic [AW-1:0]   a;
    mptr   = 0;
    mstall = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e.valid = '0; e.we = 1'b0; e.data = '0; end
      check("rsp_valid", W'(bus.rsp_valid), W'(e.valid));
      if (e.valid != '0) check("rsp_we", W'(bus.rsp_we), W'(e.we));
      check("rsp_rdata", bus.rsp_rdata, (e.valid != '0 && !e.we && !reset) ? e.data : '0);
      check("stall_cnt", W'(stall_cnt), W'(mstall));

      found = 1'b0; w = 0; xr = '0;
      if (!reset) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          int j;
          j = (mptr + k) % int'(NREQ);
          if (!found && bus.req_valid[j]) begin found = 1'b1; w = j; end
        end
      end
      if (found) xr[w] = 1'b1;
      check("req_ready", W'(bus.req_ready), W'(xr));
      check("mem_we", W'(mem_we), W'(found && bus.req_we[w]));
      a = found ? bus.req_addr[w*AW +: AW] : '0;
      check("mem_addr", W'(mem_addr), W'(a));
      check("mem_wdata", mem_wdata, (found && bus.req_we[w]) ? bus.req_wdata[w*W +: W] : '0);

      if (found) begin
        e.valid = xr;
        e.we    = bus.req_we[w];
        e.data  = bus.req_we[w] ? '0 : ref_mem[a];
        exp_q.push_back(e);
        if (bus.req_we[w]) ref_mem[a] = bus.req_wdata[w*W +: W];
        mptr = (w + 1) % int'(NREQ);
      end
      if (reset) begin
        mptr   = 0;
        mstall = '0;
      end else if (|(bus.req_valid & ~xr) && mstall != '1) begin
        mstall = mstall + 1'b1;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (opq[i].size() > 0) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_we[i]             = opq[i][0].we;
        bus.req_addr[i*AW +: AW]  = opq[i][0].addr;
        bus.req_wdata[i*W +: W]   = opq[i][0].data;
      end else begin
        bus.req_valid[i]          = 1'b0;
        bus.req_we[i]             = 1'b0;
        bus.req_addr[i*AW +: AW]  = '0;
        bus.req_wdata[i*W +: W]   = '0;
      end
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < int'(NREQ); i++) n += opq[i].size();
    return n;
  endfunction

  // Called at posedge+1; runs up to ncyc cycles, popping ops as they handshake.
  task automatic run_ops(input int ncyc, input bit must_drain);
    int n = 0;
    logic [NREQ-1:0] fired;
    drive();
    while (pending() > 0 && n < ncyc) begin
      @(negedge clk);
      fired = bus.req_valid & bus.req_ready;
      for (int i = 0; i < int'(NREQ); i++)
        if (fired[i]) begin void'(opq[i].pop_front()); glog.push_back(i); end
      @(posedge clk); #1;
      n++;
      drive();
    end
    if (must_drain) check("drain", W'(pending()), '0);
  endtask

  task automatic push_op(input int r, input logic we, input int addr, input logic [W-1:0] d);
    op_t o;
    o.we = we; o.addr = AW'(addr); o.data = d;
    opq[r].push_back(o);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    step(2);
    reset = 1'b0;
  endtask

  function automatic int glog_at(input int k);
    return (glog.size() > k) ? glog[k] : 99;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] v;
    for (int a = 0; a < 2**AW; a++) begin
      mem[a]     = init_word(a);
      ref_mem[a] = init_word(a);
    end
    v = {32'd1, 32'd2, 32'd3, 32'd4};
    mem[8] = v;
    ref_mem[8] = v;
    sat_mem_rdata = '0;
    sat_bus.req_valid = '0;
    sat_bus.req_we    = '0;
    sat_bus.req_addr  = '0;
    sat_bus.req_wdata = '0;
    drive();
    step(3);
    reset = 1'b0;
    check("rst_stall", W'(stall_cnt), '0);
    check("rst_ready", W'(bus.req_ready), '0);

    // Single load from R2
    glog.delete();
    push_op(2, 1'b0, 8, '0);
    run_ops(50, 1'b1);
    check("load_grant", W'(glog_at(0)), W'(2));
    step(1);
    check("load_stall", W'(stall_cnt), '0);

    // Round-robin with all four continuously valid
    do_reset();
    glog.delete();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < int'(NREQ); i++) push_op(i, 1'b0, 16 + i*4 + k, '0);
    run_ops(8, 1'b0);
    check("rr_stall8", W'(stall_cnt), W'(8));
    for (int k = 0; k < 8; k++) check("rr_order", W'(glog_at(k)), W'(k % 4));
    run_ops(100, 1'b1);
    step(1);

    // Pointer skip: ptr=1 with R0 and R3 valid
    do_reset();
    push_op(0, 1'b0, 3, '0);
    run_ops(20, 1'b1);
    glog.delete();
    push_op(0, 1'b0, 4, '0);
    push_op(3, 1'b0, 5, '0);
    run_ops(20, 1'b1);
    push_op(0, 1'b0, 6, '0);
    push_op(1, 1'b0, 7, '0);
    run_ops(20, 1'b1);
    check("skip_first", W'(glog_at(0)), W'(3));
    check("skip_second", W'(glog_at(1)), W'(0));
    check("skip_ptr1", W'(glog_at(2)), W'(1));
    check("skip_ptr1b", W'(glog_at(3)), W'(0));
    step(1);

    // Store then load at the same address from R1
    v = {32'd5, 32'd6, 32'd7, 32'd8};
    push_op(1, 1'b1, 9, v);
    push_op(1, 1'b0, 9, '0);
    run_ops(20, 1'b1);
    step(2);
    check("st_mem9", mem[9], v);

    // Reset asserted the cycle after an R0 grant
    do_reset();
    push_op(0, 1'b1, 20, {4{32'hdead_beef}});
    run_ops(20, 1'b1);
    reset = 1'b1;
    bus.req_valid = '1;
    bus.req_we    = '1;
    @(negedge clk);
    check("rst_mid_rsp", W'(bus.rsp_valid), W'(4'b0001));
    check("rst_mid_ready", W'(bus.req_ready), '0);
    check("rst_mid_we", W'(mem_we), '0);
    step(1);
    check("rst_mid_clr", W'(bus.rsp_valid), '0);
    step(1);
    reset = 1'b0;
    drive();
    check("rst_mid_stall", W'(stall_cnt), '0);
    glog.delete();
    push_op(0, 1'b0, 21, '0);
    push_op(3, 1'b0, 22, '0);
    run_ops(20, 1'b1);
    check("rst_mid_ptr", W'(glog_at(0)), W'(0));
    step(1);

    // Saturation on the SW=4 instance
    do_reset();
    sat_bus.req_valid = 4'b0011;
    step(10);
    check("sat_10", W'(sat_stall_cnt), W'(10));
    step(10);
    check("sat_15", W'(sat_stall_cnt), W'(15));
    sat_bus.req_valid = '0;
    step(2);

    check("sb_empty", W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
